// File: rtl/decode_stage_pkg.sv
// Package rv32i: micro-op encoding, decode result type and immediate helpers shared by the
// decode stage and its combinational decoder. Optional M extension: DECODE_RV32M_EN.
package rv32i;

    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND,
        ALU_EQ, ALU_NE, ALU_LT, ALU_GE, ALU_LTU, ALU_GEU,
        ALU_CSRW, ALU_CSRS, ALU_CSRC,
        ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
    } alu_op_t;

    typedef enum logic [2:0] {
        PC_INPUT_PLUS4, PC_INPUT_BRANCH, PC_INPUT_JAL, PC_INPUT_JALR, PC_INPUT_CSR
    } pc_input_t;

    typedef enum logic [1:0] {
        ALU_INPUT1_RS1, ALU_INPUT1_PC, ALU_INPUT1_ZERO, ALU_INPUT1_CSR
    } alu_input1_t;

    typedef enum logic [1:0] {
        ALU_INPUT2_RS2, ALU_INPUT2_IMM, ALU_INPUT2_RS1
    } alu_input2_t;

    typedef enum logic [2:0] {
        WB_NONE, WB_ALU, WB_MEM, WB_PC4, WB_CSR
    } wb_from_t;

    // Mask encodings mirror the LOAD/STORE funct3 field so decode can cast it directly.
    typedef enum logic [2:0] {
        MASK_B = 3'b000, MASK_H = 3'b001, MASK_W = 3'b010, MASK_BU = 3'b100, MASK_HU = 3'b101
    } mask_t;

    typedef enum logic { REG_WD = 1'b0, REG_WE = 1'b1 } we_t;
    typedef enum logic { MEM_LOAD = 1'b0, MEM_STORE = 1'b1 } mem_op_t;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [11:0] csr_addr;
        logic [4:0]  zimm;
        alu_op_t     alu_op;
        pc_input_t   pc_input_type;
        alu_input1_t alu_input1_type;
        alu_input2_t alu_input2_type;
        wb_from_t    wb_from;
        mask_t       reg_mask;
        mask_t       ram_mask;
        we_t         r_we;
        mem_op_t     mem_op;
        we_t         csr_we;
    } uop_t;

    localparam uop_t UOP_NOP = '{
        rs1: 5'd0, rs2: 5'd0, rd: 5'd0, imm: 32'd0, csr_addr: 12'd0, zimm: 5'd0,
        alu_op: ALU_ADD, pc_input_type: PC_INPUT_PLUS4,
        alu_input1_type: ALU_INPUT1_RS1, alu_input2_type: ALU_INPUT2_IMM,
        wb_from: WB_NONE, reg_mask: MASK_W, ram_mask: MASK_W,
        r_we: REG_WD, mem_op: MEM_LOAD, csr_we: REG_WD
    };

    typedef struct packed {
        uop_t uop;
        logic illegal;
    } decode_result_t;

    function automatic logic [31:0] imm_i(input logic [31:0] i);
        return {{20{i[31]}}, i[31:20]};
    endfunction

    function automatic logic [31:0] imm_s(input logic [31:0] i);
        return {{20{i[31]}}, i[31:25], i[11:7]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] i);
        return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] i);
        return {i[31:12], 12'd0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] i);
        return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/decode_stage_core.sv
// decode_core: purely combinational RV32I instruction decoder producing one micro-op plus an
// illegal flag. DECODE_RV32M_EN enables the M-extension encodings on the OP opcode.
module decode_core
    import rv32i::*;
(
    input  logic [31:0]    instr,
    output decode_result_t result
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    uop_t       uop;
    logic       illegal;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        uop     = UOP_NOP;
        illegal = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                uop.rd              = instr[11:7];
                uop.imm             = imm_u(instr);
                uop.alu_input1_type = (opcode == OPC_LUI) ? ALU_INPUT1_ZERO : ALU_INPUT1_PC;
                uop.wb_from         = WB_ALU;
                uop.r_we            = REG_WE;
            end
            OPC_JAL: begin
                uop.rd              = instr[11:7];
                uop.imm             = imm_j(instr);
                uop.alu_input1_type = ALU_INPUT1_PC;
                uop.pc_input_type   = PC_INPUT_JAL;
                uop.wb_from         = WB_PC4;
                uop.r_we            = REG_WE;
            end
            OPC_JALR: begin
                uop.rs1           = instr[19:15];
                uop.rd            = instr[11:7];
                uop.imm           = imm_i(instr);
                uop.pc_input_type = PC_INPUT_JALR;
                uop.wb_from       = WB_PC4;
                uop.r_we          = REG_WE;
            end
            OPC_BRANCH: begin
                uop.rs1             = instr[19:15];
                uop.rs2             = instr[24:20];
                uop.imm             = imm_b(instr);
                uop.alu_input2_type = ALU_INPUT2_RS2;
                uop.pc_input_type   = PC_INPUT_BRANCH;
                case (funct3)
                    3'b000:  uop.alu_op = ALU_EQ;
                    3'b001:  uop.alu_op = ALU_NE;
                    3'b100:  uop.alu_op = ALU_LT;
                    3'b101:  uop.alu_op = ALU_GE;
                    3'b110:  uop.alu_op = ALU_LTU;
                    3'b111:  uop.alu_op = ALU_GEU;
                    default: illegal = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                uop.rs1      = instr[19:15];
                uop.rd       = instr[11:7];
                uop.imm      = imm_i(instr);
                uop.wb_from  = WB_MEM;
                uop.r_we     = REG_WE;
                uop.reg_mask = mask_t'(funct3);
                illegal      = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OPC_STORE: begin
                uop.rs1      = instr[19:15];
                uop.rs2      = instr[24:20];
                uop.imm      = imm_s(instr);
                uop.mem_op   = MEM_STORE;
                uop.ram_mask = mask_t'(funct3);
                illegal      = (funct3 >= 3'b011);
            end
            OPC_OP_IMM: begin
                uop.rs1     = instr[19:15];
                uop.rd      = instr[11:7];
                uop.imm     = imm_i(instr);
                uop.wb_from = WB_ALU;
                uop.r_we    = REG_WE;
                case (funct3)
                    3'b000: uop.alu_op = ALU_ADD;
                    3'b010: uop.alu_op = ALU_SLT;
                    3'b011: uop.alu_op = ALU_SLTU;
                    3'b100: uop.alu_op = ALU_XOR;
                    3'b110: uop.alu_op = ALU_OR;
                    3'b111: uop.alu_op = ALU_AND;
                    3'b001: begin
                        uop.alu_op = ALU_SLL;
                        uop.imm    = {27'd0, instr[24:20]};
                        illegal    = (funct7 != 7'b0000000);
                    end
                    default: begin
                        uop.alu_op = (funct7 == 7'b0100000) ? ALU_SRA : ALU_SRL;
                        uop.imm    = {27'd0, instr[24:20]};
                        illegal    = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
                    end
                endcase
            end
            OPC_OP: begin
                uop.rs1             = instr[19:15];
                uop.rs2             = instr[24:20];
                uop.rd              = instr[11:7];
                uop.alu_input2_type = ALU_INPUT2_RS2;
                uop.wb_from         = WB_ALU;
                uop.r_we            = REG_WE;
                case (funct7)
                    7'b0000000: begin
                        case (funct3)
                            3'b000:  uop.alu_op = ALU_ADD;
                            3'b001:  uop.alu_op = ALU_SLL;
                            3'b010:  uop.alu_op = ALU_SLT;
                            3'b011:  uop.alu_op = ALU_SLTU;
                            3'b100:  uop.alu_op = ALU_XOR;
                            3'b101:  uop.alu_op = ALU_SRL;
                            3'b110:  uop.alu_op = ALU_OR;
                            default: uop.alu_op = ALU_AND;
                        endcase
                    end
                    7'b0100000: begin
                        case (funct3)
                            3'b000:  uop.alu_op = ALU_SUB;
                            3'b101:  uop.alu_op = ALU_SRA;
                            default: illegal = 1'b1;
                        endcase
                    end
`ifdef DECODE_RV32M_EN
                    7'b0000001: begin
                        case (funct3)
                            3'b000:  uop.alu_op = ALU_MUL;
                            3'b001:  uop.alu_op = ALU_MULH;
                            3'b010:  uop.alu_op = ALU_MULHSU;
                            3'b011:  uop.alu_op = ALU_MULHU;
                            3'b100:  uop.alu_op = ALU_DIV;
                            3'b101:  uop.alu_op = ALU_DIVU;
                            3'b110:  uop.alu_op = ALU_REM;
                            default: uop.alu_op = ALU_REMU;
                        endcase
                    end
`else
`endif
                    default: illegal = 1'b1;
                endcase
            end
            OPC_MISC_MEM: ;  // FENCE / FENCE.I have no effect in this pipeline
            OPC_SYSTEM: begin
                uop.csr_addr = instr[31:20];
                case (funct3)
                    3'b000:  uop.pc_input_type = PC_INPUT_CSR;
                    3'b100:  illegal = 1'b1;
                    default: begin
                        // Immediate forms carry zimm in the rs1 slot; keep rs1 clear so no
                        // register read or hazard is implied.
                        uop.rd              = instr[11:7];
                        uop.alu_input1_type = ALU_INPUT1_CSR;
                        uop.wb_from         = WB_CSR;
                        uop.r_we            = REG_WE;
                        uop.csr_we          = REG_WE;
                        if (funct3[2]) begin
                            uop.zimm            = instr[19:15];
                            uop.imm             = {27'd0, instr[19:15]};
                            uop.alu_input2_type = ALU_INPUT2_IMM;
                        end else begin
                            uop.rs1             = instr[19:15];
                            uop.alu_input2_type = ALU_INPUT2_RS1;
                        end
                        case (funct3[1:0])
                            2'b01:   uop.alu_op = ALU_CSRW;
                            2'b10:   uop.alu_op = ALU_CSRS;
                            default: uop.alu_op = ALU_CSRC;
                        endcase
                    end
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

    assign result.uop     = illegal ? UOP_NOP : uop;
    assign result.illegal = illegal;

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decode between fetch and execute, queuing decoded uops in a
// DEPTH-entry FIFO with valid/ready on both sides. M extension via DECODE_RV32M_EN.
module decode_stage
    import rv32i::*;
#(
    parameter int DEPTH    = 2,
    parameter int PC_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [PC_WIDTH-1:0] in_pc,
    input  logic [31:0]         in_instr,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PC_WIDTH-1:0] out_pc,
    output uop_t                out_uop,
    output logic                out_illegal
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
        decode_result_t      res;
    } entry_t;

    entry_t             mem [DEPTH];
    entry_t             last_q;
    entry_t             head;
    decode_result_t     dec;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               push;
    logic               pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    decode_core u_core (
        .instr  (in_instr),
        .result (dec)
    );

    // Ready depends only on registered occupancy so there is no out_ready -> in_ready path.
    assign in_ready  = (count < CNT_W'(DEPTH)) && !flush;
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; count gates every read, so stale entries are
    // never visible.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{pc: in_pc, res: dec};
    end

    // Remembers the last head shown so outputs hold steady while the queue is empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= '{pc: '0, res: '{uop: UOP_NOP, illegal: 1'b0}};
        end else if (out_valid) begin
            last_q <= mem[rd_ptr];
        end
    end

    assign head        = out_valid ? mem[rd_ptr] : last_q;
    assign out_pc      = head.pc;
    assign out_uop     = head.res.uop;
    assign out_illegal = head.res.illegal;

endmodule
